// File: rtl/shifter_ctrl.sv
// shifter_ctrl: burst sequencer for the memory lane-rotate shifter.
// Define SHIFTER_CTRL_PERF_EN to add stall/bubble performance counters.
module shifter_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DATA   = 4,
  parameter int CTRL_WIDTH = $clog2(NUM_DATA),
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [CTRL_WIDTH-1:0] CMD_OFFSET,
  input  logic [CTRL_WIDTH-1:0] CMD_STRIDE,
  input  logic [LEN_WIDTH-1:0]  CMD_LEN,
  input  logic                  BEAT_VALID,
  output logic                  BEAT_READY,
  output logic                  SHIFT_RD_EN,
  output logic [CTRL_WIDTH-1:0] SHIFT_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  DONE
`ifdef SHIFTER_CTRL_PERF_EN
  ,
  output logic [31:0]           PERF_STALL_CNT,
  output logic [31:0]           PERF_BUBBLE_CNT
`endif
);

  if (DATA_WIDTH < 1 || NUM_DATA < 2 ||
      (NUM_DATA & (NUM_DATA - 1)) != 0 ||
      CTRL_WIDTH != $clog2(NUM_DATA)) begin : g_param_chk
    $error("shifter_ctrl: illegal parameters");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [CTRL_WIDTH-1:0] offset;
  logic [CTRL_WIDTH-1:0] stride;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  out_valid;
  logic                  out_last;
  logic                  done;
  logic                  in_idle;
  logic                  in_run;
  logic                  in_drain;
  logic                  beat_hs;
  logic                  out_hs;
  logic                  last_beat;

  assign in_idle   = state == S_IDLE;
  assign in_run    = state == S_RUN;
  assign in_drain  = state == S_DRAIN;
  assign last_beat = remaining == LEN_WIDTH'(1);

  // One output slot: a new beat may enter only if the slot frees this cycle.
  assign BEAT_READY  = in_run && (!out_valid || OUT_READY);
  assign beat_hs     = BEAT_VALID && BEAT_READY;
  assign out_hs      = out_valid && OUT_READY;
  assign SHIFT_RD_EN = beat_hs;
  assign SHIFT_CTRL  = beat_hs ? offset : ctrl_q;
  assign CMD_READY   = in_idle;
  assign BUSY        = !in_idle;
  assign OUT_VALID   = out_valid;
  assign OUT_LAST    = out_last;
  assign DONE        = done;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      offset    <= '0;
      stride    <= '0;
      remaining <= '0;
      ctrl_q    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        in_idle: begin
          if (CMD_VALID) begin
            offset    <= CMD_OFFSET;
            stride    <= CMD_STRIDE;
            remaining <= CMD_LEN;
            if (CMD_LEN == '0) done  <= 1'b1;
            else               state <= S_RUN;
          end
        end
        in_run: begin
          if (beat_hs) begin
            ctrl_q    <= offset;
            offset    <= offset + stride;
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_beat) state <= S_DRAIN;
          end
        end
        in_drain: begin
          if (out_hs) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (beat_hs) begin
      out_valid <= 1'b1;
      out_last  <= last_beat;
    end else if (OUT_READY) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef SHIFTER_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (in_idle && CMD_VALID) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (in_run) begin
      if (BEAT_VALID && !BEAT_READY && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (!BEAT_VALID && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign PERF_STALL_CNT  = stall_cnt;
  assign PERF_BUBBLE_CNT = bubble_cnt;
`endif

endmodule

// File: tb/tb_shifter_ctrl.sv
// tb_shifter_ctrl: randomized bench for shifter_ctrl with a lane-rotate
// shifter model and a burst-level reference model.
module tb_shifter_ctrl;
  localparam int DW   = 16;
  localparam int ND   = 4;
  localparam int CW   = 2;
  localparam int LW   = 8;
  localparam int WW   = DW * ND;
  localparam int MAXC = 400;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [CW-1:0] CMD_OFFSET = '0;
  logic [CW-1:0] CMD_STRIDE = '0;
  logic [LW-1:0] CMD_LEN = '0;
  logic          BEAT_VALID = 1'b0;
  logic          BEAT_READY;
  logic          SHIFT_RD_EN;
  logic [CW-1:0] SHIFT_CTRL;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          OUT_LAST;
  logic          BUSY;
  logic          DONE;
  logic [WW-1:0] beat_data = '0;
  logic [WW-1:0] data_out = '0;

  int nchk = 0;
  int nerr = 0;

  shifter_ctrl #(
    .DATA_WIDTH(DW), .NUM_DATA(ND), .CTRL_WIDTH(CW), .LEN_WIDTH(LW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OFFSET(CMD_OFFSET), .CMD_STRIDE(CMD_STRIDE), .CMD_LEN(CMD_LEN),
    .BEAT_VALID(BEAT_VALID), .BEAT_READY(BEAT_READY),
    .SHIFT_RD_EN(SHIFT_RD_EN), .SHIFT_CTRL(SHIFT_CTRL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 ACLK = ~ACLK;

  // Shifter: output lane i takes input lane (i+ctrl) mod ND.
  always @(posedge ACLK)
    if (SHIFT_RD_EN)
      for (int i = 0; i < ND; i++)
        data_out[i*DW +: DW] <= beat_data[((i + int'(SHIFT_CTRL)) % ND)*DW +: DW];

  function automatic logic [WW-1:0] ref_word(input logic [WW-1:0] d, input int c);
    logic [2*WW-1:0] dd;
    dd = {d, d};
    dd = dd >> (c * DW);
    return dd[WW-1:0];
  endfunction

  function automatic int ref_ctrl(input int off, input int str, input int k);
    return (off + k * str) % ND;
  endfunction

  logic [WW-1:0] beats[$];
  int            o_ctrl[$];
  logic [WW-1:0] o_data[$];
  bit            o_last[$];
  int            o_hs_cyc[$];
  int            o_out_cyc[$];
  int            o_done_cnt, o_done_cyc, o_rd_bad, o_stall_bad;
  int            o_inj_ready, o_cmd_ready, o_ready_at_done;
  bit            o_busy_seen, o_timeout;

  task automatic drive_burst(input int off, input int str, input int len,
                             input int vprob, input int rprob, input int stall_n,
                             input int inject_at, input int abort_after);
    int cyc, idx, hs_n, stall_left;
    bit hs_pend, stall_used;
    logic [WW-1:0] held;
    beats.delete(); o_ctrl.delete(); o_data.delete(); o_last.delete();
    o_hs_cyc.delete(); o_out_cyc.delete();
    for (int k = 0; k < len; k++) beats.push_back({$urandom, $urandom});
    o_done_cnt = 0; o_done_cyc = -1; o_rd_bad = 0; o_stall_bad = 0;
    o_inj_ready = -1; o_ready_at_done = -1; o_busy_seen = 0; o_timeout = 0;
    @(negedge ACLK);
    CMD_VALID = 1'b1; CMD_OFFSET = CW'(off); CMD_STRIDE = CW'(str);
    CMD_LEN = LW'(len); BEAT_VALID = 1'b0; OUT_READY = 1'b1;
    #1 o_cmd_ready = int'(CMD_READY);
    cyc = 0; idx = 0; hs_n = 0; hs_pend = 0;
    stall_left = 0; stall_used = 0; held = '0;
    forever begin
      @(negedge ACLK);
      if (hs_pend) begin idx++; hs_pend = 0; end
      CMD_VALID = (cyc == inject_at);
      if (cyc == inject_at) begin
        CMD_OFFSET = CW'(off + 2); CMD_STRIDE = CW'(str + 1); CMD_LEN = LW'(9);
      end
      BEAT_VALID = (idx < len) && (int'($urandom_range(99)) < vprob);
      if (idx < len) beat_data = beats[idx];
      else beat_data = '0;
      if (OUT_VALID && !stall_used && stall_n > 0) begin
        stall_left = stall_n; stall_used = 1; held = data_out;
      end
      if (stall_left > 0) OUT_READY = 1'b0;
      else OUT_READY = int'($urandom_range(99)) < rprob;
      #1;
      if (stall_left > 0) begin
        if (BEAT_READY || SHIFT_RD_EN || data_out !== held) o_stall_bad++;
        stall_left--;
      end
      if (cyc == inject_at) o_inj_ready = int'(CMD_READY);
      if (BUSY) o_busy_seen = 1;
      if (SHIFT_RD_EN !== (BEAT_VALID && BEAT_READY)) o_rd_bad++;
      if (SHIFT_RD_EN) begin
        o_ctrl.push_back(int'(SHIFT_CTRL)); o_hs_cyc.push_back(cyc);
        hs_pend = 1; hs_n++;
      end
      if (OUT_VALID && OUT_READY) begin
        o_data.push_back(data_out); o_last.push_back(OUT_LAST);
        o_out_cyc.push_back(cyc);
      end
      if (DONE) begin
        o_done_cnt++;
        if (o_done_cyc < 0) begin
          o_done_cyc = cyc; o_ready_at_done = int'(CMD_READY);
        end
      end
      cyc++;
      if (abort_after > 0 && hs_n >= abort_after) break;
      if (o_done_cnt > 0) break;
      if (cyc >= MAXC) begin o_timeout = 1; break; end
    end
    if (abort_after == 0 && !o_timeout) begin
      repeat (2) begin
        @(negedge ACLK);
        CMD_VALID = 1'b0; BEAT_VALID = 1'b0; OUT_READY = 1'b1;
        #1;
        if (DONE) o_done_cnt++;
        if (SHIFT_RD_EN) o_rd_bad++;
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] got;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    #1 got = {CMD_READY, BUSY, DONE, OUT_VALID, OUT_LAST,
              BEAT_READY, SHIFT_RD_EN, SHIFT_CTRL};
    nchk++;
    if (got !== 9'b1_0000_0000) begin
      nerr++; $display("FAIL reset_hold got %b want 100000000", got);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    #1 got = {CMD_READY, BUSY, DONE, OUT_VALID, OUT_LAST,
              BEAT_READY, SHIFT_RD_EN, SHIFT_CTRL};
    nchk++;
    if (got !== 9'b1_0000_0000) begin
      nerr++; $display("FAIL reset_release got %b want 100000000", got);
    end
  endtask

  task automatic test_single_beat();
    drive_burst(1, 0, 1, 100, 100, 0, -1, 0);
    nchk++;
    if (o_ctrl.size() != 1 || o_ctrl[0] != 1) begin
      nerr++; $display("FAIL single_ctrl got n=%0d want one beat ctrl 1", o_ctrl.size());
    end
    nchk++;
    if (o_out_cyc.size() != 1 || o_hs_cyc.size() != 1 ||
        o_out_cyc[0] != o_hs_cyc[0] + 1 || o_last[0] != 1'b1) begin
      nerr++; $display("FAIL single_out got n=%0d want 1 output next cycle with last", o_out_cyc.size());
    end
    nchk++;
    if (o_data.size() != 1 || o_data[0] !== ref_word(beats[0], 1)) begin
      nerr++; $display("FAIL single_data got n=%0d want rotated word", o_data.size());
    end
    nchk++;
    if (o_out_cyc.size() != 1 || o_done_cyc != o_out_cyc[0] + 1 ||
        o_ready_at_done != 1 || o_done_cnt != 1) begin
      nerr++;
      $display("FAIL single_done got cyc=%0d ready=%0d cnt=%0d want cyc after output, 1, 1",
               o_done_cyc, o_ready_at_done, o_done_cnt);
    end
  endtask

  task automatic test_wrap();
    int exp_seq[5] = '{3, 0, 1, 2, 3};
    drive_burst(3, 1, 5, 100, 100, 0, -1, 0);
    nchk++;
    if (o_ctrl.size() != 5 || o_hs_cyc[4] - o_hs_cyc[0] != 4) begin
      nerr++; $display("FAIL wrap_hs got n=%0d want 5 consecutive", o_ctrl.size());
    end
    for (int k = 0; k < 5 && k < o_ctrl.size(); k++) begin
      nchk++;
      if (o_ctrl[k] != exp_seq[k]) begin
        nerr++; $display("FAIL wrap_ctrl[%0d] got %0d want %0d", k, o_ctrl[k], exp_seq[k]);
      end
    end
    nchk++;
    if (o_data.size() != 5) begin
      nerr++; $display("FAIL wrap_count got %0d want 5", o_data.size());
    end
    for (int k = 0; k < 5 && k < o_data.size(); k++) begin
      nchk++;
      if (o_data[k] !== ref_word(beats[k], exp_seq[k]) || o_last[k] != (k == 4)) begin
        nerr++; $display("FAIL wrap_out[%0d] got %h last=%0b want %h last=%0b",
                         k, o_data[k], o_last[k], ref_word(beats[k], exp_seq[k]), k == 4);
      end
    end
  endtask

  task automatic test_backpressure();
    int off, str;
    off = int'($urandom_range(3)); str = int'($urandom_range(3));
    drive_burst(off, str, 4, 100, 100, 3, -1, 0);
    nchk++;
    if (o_stall_bad != 0) begin
      nerr++; $display("FAIL bp_stall got %0d bad cycles want 0", o_stall_bad);
    end
    nchk++;
    if (o_data.size() != 4 || o_done_cnt != 1) begin
      nerr++; $display("FAIL bp_count got %0d outs %0d done want 4 1", o_data.size(), o_done_cnt);
    end
    for (int k = 0; k < 4 && k < o_data.size(); k++) begin
      nchk++;
      if (o_data[k] !== ref_word(beats[k], ref_ctrl(off, str, k)) || o_last[k] != (k == 3)) begin
        nerr++; $display("FAIL bp_out[%0d] got %h last=%0b want %h last=%0b", k, o_data[k],
                         o_last[k], ref_word(beats[k], ref_ctrl(off, str, k)), k == 3);
      end
    end
  endtask

  task automatic test_zero_len();
    drive_burst(int'($urandom_range(3)), int'($urandom_range(3)), 0, 100, 100, 0, -1, 0);
    nchk++;
    if (o_ctrl.size() != 0 || o_busy_seen || o_data.size() != 0) begin
      nerr++; $display("FAIL zero_activity got rd=%0d busy=%0b want 0 0", o_ctrl.size(), o_busy_seen);
    end
    nchk++;
    if (o_done_cnt != 1 || o_done_cyc != 0) begin
      nerr++; $display("FAIL zero_done got cnt=%0d cyc=%0d want 1 0", o_done_cnt, o_done_cyc);
    end
  endtask

  task automatic test_cmd_while_busy();
    drive_burst(2, 3, 6, 100, 100, 0, 2, 0);
    nchk++;
    if (o_cmd_ready != 1 || o_inj_ready != 0) begin
      nerr++; $display("FAIL busy_ready got first=%0d busy=%0d want 1 0", o_cmd_ready, o_inj_ready);
    end
    nchk++;
    if (o_ctrl.size() != 6 || o_data.size() != 6 || o_done_cnt != 1) begin
      nerr++; $display("FAIL busy_count got %0d %0d %0d want 6 6 1",
                       o_ctrl.size(), o_data.size(), o_done_cnt);
    end
    for (int k = 0; k < 6 && k < o_data.size() && k < o_ctrl.size(); k++) begin
      nchk++;
      if (o_ctrl[k] != ref_ctrl(2, 3, k) || o_data[k] !== ref_word(beats[k], ref_ctrl(2, 3, k))) begin
        nerr++; $display("FAIL busy_beat[%0d] got ctrl %0d want %0d", k, o_ctrl[k], ref_ctrl(2, 3, k));
      end
    end
  endtask

  task automatic test_random();
    int off, str, len;
    for (int n = 0; n < 25; n++) begin
      off = int'($urandom_range(3)); str = int'($urandom_range(3));
      len = int'($urandom_range(12, 1));
      drive_burst(off, str, len, int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 30)), 0, -1, 0);
      nchk++;
      if (o_timeout || o_done_cnt != 1 || o_rd_bad != 0) begin
        nerr++; $display("FAIL rand_proto[%0d] got done=%0d rd_bad=%0d timeout=%0b want 1 0 0",
                         n, o_done_cnt, o_rd_bad, o_timeout);
      end
      nchk++;
      if (o_ctrl.size() != len || o_data.size() != len) begin
        nerr++; $display("FAIL rand_count[%0d] got %0d %0d want %0d",
                         n, o_ctrl.size(), o_data.size(), len);
      end
      for (int k = 0; k < len && k < o_ctrl.size(); k++) begin
        nchk++;
        if (o_ctrl[k] != ref_ctrl(off, str, k)) begin
          nerr++; $display("FAIL rand_ctrl[%0d.%0d] got %0d want %0d",
                           n, k, o_ctrl[k], ref_ctrl(off, str, k));
        end
      end
      for (int k = 0; k < len && k < o_data.size(); k++) begin
        nchk++;
        if (o_data[k] !== ref_word(beats[k], ref_ctrl(off, str, k)) ||
            o_last[k] != (k == len - 1)) begin
          nerr++; $display("FAIL rand_out[%0d.%0d] got %h last=%0b want %h last=%0b", n, k,
                           o_data[k], o_last[k], ref_word(beats[k], ref_ctrl(off, str, k)),
                           k == len - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] got;
    int dn;
    int off, str;
    drive_burst(1, 1, 6, 100, 100, 0, -1, 2);
    nchk++;
    if (o_ctrl.size() != 2 || o_timeout) begin
      nerr++; $display("FAIL abort_pre got %0d beats want 2", o_ctrl.size());
    end
    @(negedge ACLK);
    BEAT_VALID = 1'b0; ARESETN = 1'b0;
    #1 got = {OUT_VALID, OUT_LAST, DONE, BUSY, BEAT_READY, SHIFT_RD_EN, SHIFT_CTRL};
    nchk++;
    if (got !== 8'h00 || CMD_READY !== 1'b1) begin
      nerr++; $display("FAIL abort_outputs got %b ready=%b want 00000000 1", got, CMD_READY);
    end
    dn = 0;
    repeat (2) begin @(negedge ACLK); #1 if (DONE) dn++; end
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) begin @(negedge ACLK); #1 if (DONE) dn++; end
    nchk++;
    if (dn != 0) begin
      nerr++; $display("FAIL abort_no_done got %0d pulses want 0", dn);
    end
    off = int'($urandom_range(3)); str = int'($urandom_range(3));
    drive_burst(off, str, 2, 100, 100, 0, -1, 0);
    nchk++;
    if (o_data.size() != 2 || o_done_cnt != 1) begin
      nerr++; $display("FAIL abort_next got %0d outs %0d done want 2 1", o_data.size(), o_done_cnt);
    end
    for (int k = 0; k < 2 && k < o_data.size(); k++) begin
      nchk++;
      if (o_data[k] !== ref_word(beats[k], ref_ctrl(off, str, k)) || o_last[k] != (k == 1)) begin
        nerr++; $display("FAIL abort_next_out[%0d] got %h want %h", k, o_data[k],
                         ref_word(beats[k], ref_ctrl(off, str, k)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_cmd_while_busy();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/shifter_ctrl.md
Name: shifter_ctrl

Overview:
- Sequences the memory-interface lane shifter (rotate-right by CTRL lanes of a NUM_DATA x DATA_WIDTH word) for burst reads.
- Accepts one burst command: start lane offset, per-beat offset stride, beat count.
- Per beat, handshakes incoming memory beats, drives the shifter read enable and rotation control, and presents an output valid/ready/last stream aligned to the shifter's one-cycle registered output.

Parameters:
- DATA_WIDTH, 16, lane width in bits; passed through for consistency checks only.
- NUM_DATA, 4, lanes per word; power of two, >= 2.
- CTRL_WIDTH, `C_LOG_2(NUM_DATA), rotation control width.
- LEN_WIDTH, 8, beat-count width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  burst command valid.
- CMD_READY  out  1  controller idle and able to accept a command.
- CMD_OFFSET  in  CTRL_WIDTH  rotation amount for the first beat.
- CMD_STRIDE  in  CTRL_WIDTH  rotation increment per beat, modulo NUM_DATA.
- CMD_LEN  in  LEN_WIDTH  number of beats; 0 is legal.
- BEAT_VALID  in  1  memory data beat present at shifter DATA_IN.
- BEAT_READY  out  1  beat accepted this cycle when both high.
- SHIFT_RD_EN  out  1  shifter read enable; equals beat handshake.
- SHIFT_CTRL  out  CTRL_WIDTH  shifter rotation control.
- OUT_VALID  in/out: out  1  shifter DATA_OUT holds a valid rotated word.
- OUT_READY  in  1  downstream consumes the word.
- OUT_LAST  out  1  current output word is the final beat of the burst.
- BUSY  out  1  high in RUN or DRAIN.
- DONE  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async on ARESETN low):
  - State = IDLE.
  - All registered outputs are 0: OUT_VALID, OUT_LAST, DONE, BUSY, SHIFT_CTRL.
  - Offset, stride, remaining-count registers are 0.
  - CMD_READY is 1 after reset release.
- Shifter contract: DATA_OUT registers on the ACLK edge where RD_EN=1 and holds otherwise. Output latency is one cycle.
- States:
  - IDLE:
    - CMD_READY=1, BEAT_READY=0.
    - On CMD_VALID: latch offset, stride, len.
    - len!=0 -> RUN.
    - len==0 -> stay IDLE and pulse DONE the next cycle; no shifter activity.
  - RUN:
    - BEAT_READY = !OUT_VALID || OUT_READY, so the single output slot never overruns.
    - On a handshake:
      - SHIFT_RD_EN=1 combinationally, with SHIFT_CTRL = current offset.
      - Offset <= (offset + stride) mod NUM_DATA; wrap by natural CTRL_WIDTH overflow.
      - Remaining decrements.
    - When the handshake consumes the last beat (remaining==1) -> DRAIN.
  - DRAIN:
    - BEAT_READY=0.
    - When OUT_VALID && OUT_READY -> IDLE; DONE pulses in the cycle after the transfer.
- SHIFT_CTRL is held at its last value when SHIFT_RD_EN=0.
- OUT_VALID:
  - Set on the edge after SHIFT_RD_EN.
  - Cleared on OUT_READY when no new RD_EN occurs in the same cycle.
  - A simultaneous consume and new beat keeps it at 1 (back-to-back throughput of 1 beat/cycle).
- OUT_LAST is registered alongside OUT_VALID: 1 for the word produced by the final beat, otherwise 0.
- A CMD_VALID while BUSY is ignored (CMD_READY=0); a command is never queued.
- Reset asserted mid-burst aborts immediately to IDLE. No DONE is issued, and beats in flight are dropped.

Optional Feature:
- Macro: SHIFTER_CTRL_PERF_EN.
- When defined, adds two outputs, both 32-bit, cleared on reset and on command acceptance, saturating at all-ones:
  - PERF_STALL_CNT counts RUN cycles with BEAT_VALID=1 and BEAT_READY=0.
  - PERF_BUBBLE_CNT counts RUN cycles with BEAT_VALID=0.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Single beat: offset=1, stride=0, len=1, NUM_DATA=4, BEAT_VALID=1, OUT_READY=1.
  -> SHIFT_RD_EN pulses once with SHIFT_CTRL=1.
  -> Next cycle OUT_VALID=1, OUT_LAST=1.
  -> Following cycle DONE=1 and CMD_READY=1.
- Wrap-around: offset=3, stride=1, len=5, continuous valid/ready.
  -> SHIFT_CTRL sequence 3,0,1,2,3 on 5 consecutive cycles.
  -> OUT_LAST only on the 5th output.
  -> Bench checks DATA_OUT equals {d,d}>>(ctrl*DATA_WIDTH) each beat.
- Backpressure: len=4, OUT_READY low for 3 cycles after the first output.
  -> BEAT_READY=0 and SHIFT_RD_EN=0 during the stall.
  -> DATA_OUT unchanged during the stall.
  -> No beat lost or duplicated; 4 outputs total.
- Zero length: len=0.
  -> No SHIFT_RD_EN, BUSY stays 0, DONE pulses once.
- Command while busy: second CMD_VALID during RUN.
  -> CMD_READY=0, command ignored, first burst completes unaffected.
- Reset mid-burst: ARESETN low after 2 of 6 beats.
  -> Outputs immediately 0, state IDLE, no DONE.
  -> A new len=2 burst then completes normally.
